// File: rtl/la_eth_stream_feeder_if.sv
// FIFO read port and UDP transmitter handshake seen by the stream feeder.
// master = feeder side, slave = FIFO/transmitter side.
interface la_eth_stream_feeder_if #(
    parameter int MEM_DQ_WIDTH = 32
);
    logic                      fifo_rd_en;
    logic [MEM_DQ_WIDTH*8-1:0] fifo_rd_data;
    logic                      fifo_empty;
    logic                      tx_start_en;
    logic [15:0]               tx_byte_num;
    logic                      tx_req;
    logic [7:0]                tx_data;
    logic                      tx_done;

    modport master (
        output fifo_rd_en, tx_start_en, tx_byte_num, tx_data,
        input  fifo_rd_data, fifo_empty, tx_req, tx_done
    );

    modport slave (
        input  fifo_rd_en, tx_start_en, tx_byte_num, tx_data,
        output fifo_rd_data, fifo_empty, tx_req, tx_done
    );
endinterface

// File: rtl/la_eth_stream_feeder.sv
// Drains the logic-analyser capture FIFO and serialises its samples into
// UDP payload frames of at most PKT_BYTES bytes.
module la_eth_stream_feeder #(
    parameter int MEM_DQ_WIDTH = 32,
    parameter int PKT_BYTES    = 1024,
    parameter int IFG_CYCLES   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            sample_num,
    input  logic                   capture_done,
    la_eth_stream_feeder_if.master bus,
    output logic                   ethernet_read_done,
    output logic                   underflow
);

    // state | meaning
    // IDLE  | no capture pending, waiting for capture_done
    // START | one-cycle tx_start_en for the next frame
    // SEND  | handing payload bytes to the transmitter on tx_req
    // WAITD | frame fully handed over, waiting for tx_done
    // GAP   | inter-frame gap before the next START
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SEND, S_WAITD, S_GAP
    } state_t;

    localparam int DW     = MEM_DQ_WIDTH * 8;
    localparam int BIDX_W = $clog2(MEM_DQ_WIDTH);
    localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int WL_W   = 27;
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(MEM_DQ_WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(IFG_CYCLES - 1);
    localparam logic [31:0]       PKT_MAX   = 32'(PKT_BYTES);

    state_t            state, state_nxt;
    logic [31:0]       remaining;
    logic [WL_W-1:0]   words_left;
    logic [DW-1:0]     cur_word, nxt_word, cur_word_n, nxt_word_n;
    logic              cur_vld, nxt_vld, cur_vld_n, nxt_vld_n;
    logic [BIDX_W-1:0] bidx;
    logic [15:0]       fcnt, byte_num;
    logic [GAP_W-1:0]  gap_cnt;
    logic              rd_pend;
    logic              cap_go, consume, wrap, last_byte;
    logic              frame_done, all_sent, gap_end, rd_issue;

    function automatic logic [15:0] frame_len(input logic [31:0] left);
        return (left > PKT_MAX) ? PKT_MAX[15:0] : left[15:0];
    endfunction

    always_comb begin
        cap_go     = (state == S_IDLE) && capture_done && (sample_num != 32'd0);
        consume    = (state == S_SEND) && bus.tx_req;
        wrap       = consume && (bidx == BIDX_LAST);
        last_byte  = consume && ((fcnt + 16'd1) == byte_num);
        frame_done = (state == S_WAITD) && bus.tx_done;
        all_sent   = frame_done && (remaining == {16'd0, byte_num});
        gap_end    = (state == S_GAP) && (gap_cnt == '0);
        // one read in flight at most, so a returning word always finds a free slot
        rd_issue   = (state != S_IDLE) && (words_left != '0) && !bus.fifo_empty &&
                     !rd_pend && (!cur_vld || !nxt_vld);

        state_nxt = state;
        case (state)
            S_IDLE:  if (cap_go)     state_nxt = S_START;
            S_START:                 state_nxt = S_SEND;
            S_SEND:  if (last_byte)  state_nxt = S_WAITD;
            S_WAITD: if (frame_done) state_nxt = all_sent ? S_IDLE : S_GAP;
            S_GAP:   if (gap_end)    state_nxt = S_START;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Shift first, then land the returning word in the oldest free slot.
    always_comb begin
        cur_word_n = cur_word;
        cur_vld_n  = cur_vld;
        nxt_word_n = nxt_word;
        nxt_vld_n  = nxt_vld;
        if (wrap) begin
            cur_word_n = nxt_word;
            cur_vld_n  = nxt_vld;
            nxt_vld_n  = 1'b0;
        end
        if (rd_pend) begin
            if (!cur_vld_n) begin
                cur_word_n = bus.fifo_rd_data;
                cur_vld_n  = 1'b1;
            end else begin
                nxt_word_n = bus.fifo_rd_data;
                nxt_vld_n  = 1'b1;
            end
        end
        if (all_sent) begin
            cur_vld_n = 1'b0;
            nxt_vld_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining          <= '0;
            words_left         <= '0;
            cur_word           <= '0;
            nxt_word           <= '0;
            cur_vld            <= 1'b0;
            nxt_vld            <= 1'b0;
            bidx               <= '0;
            fcnt               <= '0;
            byte_num           <= '0;
            gap_cnt            <= '0;
            rd_pend            <= 1'b0;
            underflow          <= 1'b0;
            ethernet_read_done <= 1'b1;
        end else begin
            cur_word <= cur_word_n;
            cur_vld  <= cur_vld_n;
            nxt_word <= nxt_word_n;
            nxt_vld  <= nxt_vld_n;
            rd_pend  <= rd_issue && !all_sent;

            if (cap_go) begin
                remaining          <= sample_num;
                words_left         <= WL_W'(({1'b0, sample_num} + 33'(MEM_DQ_WIDTH - 1)) /
                                            33'(MEM_DQ_WIDTH));
                byte_num           <= frame_len(sample_num);
                ethernet_read_done <= 1'b0;
            end else begin
                if (rd_issue)   words_left <= words_left - WL_W'(1);
                if (frame_done) remaining  <= remaining - {16'd0, byte_num};
                // remaining already reflects the previous frame by the end of the gap
                if (gap_end)    byte_num   <= frame_len(remaining);
                if (all_sent)   ethernet_read_done <= 1'b1;
            end

            if (state == S_START) fcnt <= '0;
            else if (consume)     fcnt <= fcnt + 16'd1;

            if (all_sent)     bidx <= '0;
            else if (consume) bidx <= wrap ? '0 : bidx + BIDX_W'(1);

            if (frame_done && !all_sent)             gap_cnt <= GAP_LOAD;
            else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);

            if (consume && !cur_vld) underflow <= 1'b1;
        end
    end

    assign bus.fifo_rd_en  = rd_issue;
    assign bus.tx_start_en = (state == S_START);
    assign bus.tx_byte_num = byte_num;
    assign bus.tx_data     = cur_vld ? cur_word[{bidx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_la_eth_stream_feeder.sv
// Scoreboard bench for la_eth_stream_feeder with behavioural FIFO and UDP transmitter models.
module tb_la_eth_stream_feeder;
    localparam int W   = 32;
    localparam int PKT = 1024;
    localparam int IFG = 16;

    logic        clk, rst_n, capture_done, hold_empty;
    logic [31:0] sample_num;
    logic        ethernet_read_done, underflow;

    la_eth_stream_feeder_if #(.MEM_DQ_WIDTH(W)) bus ();

    la_eth_stream_feeder #(.MEM_DQ_WIDTH(W), .PKT_BYTES(PKT), .IFG_CYCLES(IFG)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .sample_num         (sample_num),
        .capture_done       (capture_done),
        .bus                (bus),
        .ethernet_read_done (ethernet_read_done),
        .underflow          (underflow)
    );

    logic [W*8-1:0] fifo_q[$];
    logic [7:0]     exp_q[$];
    int             len_q[$];
    logic [W*8-1:0] junk_word = '1;
    int             n_checks = 0;
    int             n_fail   = 0;
    int             rd_count = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Non-show-ahead FIFO: a strobe seen in one cycle delivers its word after the next edge.
    initial begin : fifo_model
        bit pop;
        bus.fifo_empty   <= 1'b1;
        bus.fifo_rd_data <= '0;
        forever begin
            @(negedge clk);
            pop = bus.fifo_rd_en;
            @(posedge clk);
            if (pop) begin
                rd_count++;
                if (fifo_q.size() != 0) bus.fifo_rd_data <= fifo_q.pop_front();
            end
            bus.fifo_empty <= hold_empty || (fifo_q.size() == 0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, expected end of test before time limit");
        $fatal(1, "time limit reached");
    end

    function automatic logic [7:0] pat_byte(input int j, input int pat);
        return 8'((j * (2 * pat + 1) + 17 * pat) & 255);
    endfunction

    task automatic queue_frames(input int nbytes);
        int rem, f;
        rem = nbytes;
        while (rem > 0) begin
            f = (rem > PKT) ? PKT : rem;
            len_q.push_back(f);
            rem -= f;
        end
    endtask

    task automatic load_capture(input int nbytes, input int pat);
        logic [W*8-1:0] word;
        for (int w = 0; w < (nbytes + W - 1) / W; w++) begin
            for (int k = 0; k < W; k++) begin
                word[k*8 +: 8] = pat_byte(w * W + k, pat);
                if (w * W + k < nbytes) exp_q.push_back(pat_byte(w * W + k, pat));
            end
            fifo_q.push_back(word);
        end
        queue_frames(nbytes);
    endtask

    task automatic pulse_capture(input int nbytes);
        @(negedge clk);
        sample_num   = 32'(nbytes);
        capture_done = 1'b1;
        @(negedge clk);
        capture_done = 1'b0;
    endtask

    task automatic wait_start(output int cycles);
        cycles = 0;
        while (!bus.tx_start_en && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        check_val("tx_start_seen", 32'(bus.tx_start_en), 32'd1);
    endtask

    // Transmitter header latency of a few cycles, then one byte per cycle.
    task automatic send_bytes(input int n);
        logic [7:0] e;
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.tx_req = 1'b1;
            e = 'x;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            check_val("tx_data", 32'(bus.tx_data), {24'd0, e});
        end
        @(negedge clk);
        bus.tx_req = 1'b0;
    endtask

    task automatic do_frame(input bit first);
        int flen, cyc;
        flen = len_q.pop_front();
        wait_start(cyc);
        if (first) check_val("start_latency", 32'(cyc), 32'd0);
        else       check_val("ifg_cycles", 32'(cyc), 32'(IFG));
        check_val("tx_byte_num", 32'(bus.tx_byte_num), 32'(flen));
        check_val("read_done_busy", 32'(ethernet_read_done), 32'd0);
        send_bytes(flen);
        repeat (2) @(negedge clk);
        check_val("tx_byte_num_hold", 32'(bus.tx_byte_num), 32'(flen));
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check_val("read_done_after_frame", 32'(ethernet_read_done), 32'(len_q.size() == 0));
    endtask

    task automatic run_capture(input int nbytes, input int pat);
        int base;
        base = rd_count;
        load_capture(nbytes, pat);
        pulse_capture(nbytes);
        do_frame(1'b1);
        while (len_q.size() != 0) do_frame(1'b0);
        repeat (4) @(negedge clk);
        check_val("fifo_reads", 32'(rd_count - base), 32'((nbytes + W - 1) / W));
        check_val("fifo_drained", 32'(fifo_q.size()), 32'd0);
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check_val("underflow_clear", 32'(underflow), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_tx_start_en", 32'(bus.tx_start_en), 32'd0);
        check_val("rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check_val("rst_tx_byte_num", 32'(bus.tx_byte_num), 32'd0);
        check_val("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check_val("rst_read_done", 32'(ethernet_read_done), 32'd1);
        check_val("rst_underflow", 32'(underflow), 32'd0);
    endtask

    initial begin : main
        int base, cyc;
        bit active, rd_low;
        rst_n        = 1'b0;
        capture_done = 1'b0;
        sample_num   = '0;
        hold_empty   = 1'b0;
        bus.tx_req   = 1'b0;
        bus.tx_done  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // one full frame of two words, then multi-frame, then a partial tail word
        run_capture(64, 0);
        repeat (5) @(negedge clk);
        run_capture(2500, 1);
        repeat (5) @(negedge clk);
        run_capture(40, 2);
        repeat (5) @(negedge clk);

        // zero-length capture must be ignored even with data in the FIFO
        base = rd_count;
        fifo_q.push_back(junk_word);
        pulse_capture(0);
        active = 1'b0;
        rd_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.tx_start_en || bus.fifo_rd_en) active = 1'b1;
            if (!ethernet_read_done) rd_low = 1'b1;
            @(negedge clk);
        end
        check_val("zero_len_activity", 32'(active), 32'd0);
        check_val("zero_len_read_done_low", 32'(rd_low), 32'd0);
        check_val("zero_len_reads", 32'(rd_count - base), 32'd0);
        fifo_q.delete();
        repeat (3) @(negedge clk);

        // FIFO stuck empty: zeros go out, underflow latches, frame still completes
        hold_empty = 1'b1;
        base = rd_count;
        for (int i = 0; i < 100; i++) exp_q.push_back(8'h00);
        queue_frames(100);
        pulse_capture(100);
        do_frame(1'b1);
        repeat (3) @(negedge clk);
        check_val("underflow_set", 32'(underflow), 32'd1);
        check_val("underflow_reads", 32'(rd_count - base), 32'd0);
        check_val("underflow_scoreboard", 32'(exp_q.size()), 32'd0);
        hold_empty = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of SEND, then a fresh capture from byte 0
        load_capture(64, 3);
        pulse_capture(64);
        cyc = len_q.pop_front();
        wait_start(cyc);
        send_bytes(10);
        check_val("underflow_sticky", 32'(underflow), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        exp_q.delete();
        len_q.delete();
        fifo_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_capture(64, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
